game_timer: RTL and testbench
=============================

Name: game_timer

Overview:
- Countdown timer that answers the access controller during play.
- Loads a two-digit BCD duration while `reconf` is high, then counts down one second per tick while `enable` is high.
- Issues a single-cycle `timeout` pulse when the count reaches 00, which returns the access FSM from PLAY to OK.
- Drives BCD digits to the seven-segment decoders.

Parameters:
- TICK_DIV, 50000000, CLK cycles per one-second tick (minimum 2; benches use 4).
- DEFAULT_TENS, 6, BCD tens digit loaded at reset.
- DEFAULT_ONES, 0, BCD ones digit loaded at reset.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset, asynchronous, active-low.
- enable  input  1  count permission from access controller (high in PLAY).
- reconf  input  1  load request from access controller (high in SET).
- load_tens  input  4  BCD tens of the new duration.
- load_ones  input  4  BCD ones of the new duration.
- timeout  output  1  one-cycle expiry pulse.
- running  output  1  high while in RUN.
- sec_tens  output  4  current BCD tens.
- sec_ones  output  4  current BCD ones.
- warn  output  1  low-time warning (see Optional Feature).

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low on RST.
- All outputs are registered.
- Reset values:
  - state IDLE
  - sec_tens=DEFAULT_TENS, sec_ones=DEFAULT_ONES
  - prescaler=0
  - timeout=0, running=0, warn=0
- States: IDLE, RUN, EXPIRED.
- Priority per edge: reconf > state logic.
- reconf=1 (any state):
  - sec_tens/sec_ones <= load_tens/load_ones; any digit >9 is clamped to 9.
  - prescaler <= 0, state <= IDLE, timeout <= 0.
  - While reconf is held, the load repeats every cycle.
- IDLE:
  - enable=1 and count!=00 -> RUN next edge.
  - enable=1 and count==00 -> EXPIRED with timeout=1 on that same edge.
  - Otherwise stay; prescaler holds.
- RUN:
  - running=1.
  - enable=0 -> IDLE (pause); count and prescaler are held, so resuming continues the partial second.
  - enable=1: prescaler increments. At TICK_DIV-1 it wraps to 0 and the count decrements:
    - ones>0: ones-1.
    - ones==0: ones=9, tens-1.
  - Decrement result 00 -> state EXPIRED and timeout=1 on the same edge that sec_* become 00.
- EXPIRED:
  - timeout returns to 0 the cycle after the pulse (exactly one cycle high).
  - Count stays 00; enable is ignored.
  - Exit only via reconf.
- Latency:
  - First decrement occurs TICK_DIV enabled cycles after entering RUN.
  - Subsequent decrements every TICK_DIV enabled cycles.
- Count never wraps below 00. The tens digit never decrements from 0, because the 01->00 transition expires first.
- Reset mid-count: immediate return to reset values; no timeout pulse.
- Simultaneous reconf and terminal tick: reconf wins; no timeout pulse.
- Simultaneous enable fall and terminal tick: the tick is not taken (enable already low); stay at 01 in IDLE.

Optional Feature:
- Macro: GAME_TIMER_WARN_EN.
- Defined:
  - warn=1 while state is RUN or IDLE and count is 10 or less (BCD compare: tens==0, or tens==1 and ones==0).
  - warn=0 in EXPIRED and after reset when the default count is >10.
  - warn is registered and updates on the same edge as sec_*.
- Not defined: warn is tied 0 and no compare logic is built.

Test Plan:
- TICK_DIV=4, DEFAULTs 6/0. Release RST, hold enable=0 for 20 cycles -> sec=6/0, running=0, timeout=0 throughout.
- Assert reconf 1 cycle with load 0/3, then enable=1 -> sec goes 0/2 after 4 cycles, 0/1 after 8, 0/0 after 12. timeout high exactly on the 12th-cycle edge for 1 cycle; state EXPIRED; enable kept high causes no further change.
- Load 1/0, enable, and drop enable for 5 cycles after 2 enabled cycles -> count 1/0 is held during the pause. After re-enable, 0/9 appears 2 enabled cycles later (prescaler preserved; borrow across tens).
- Load 0xF/0xC with reconf -> sec=9/9 (clamp). Load 0/0, then enable -> timeout pulse on the first enabled edge, state EXPIRED.
- Load 0/1, enable, assert reconf (load 0/5) on the terminal tick cycle -> no timeout pulse; sec=0/5, state IDLE. Pull RST low mid-count -> outputs return asynchronously to 6/0, timeout=0.
- With GAME_TIMER_WARN_EN defined: load 1/1, enable -> warn=0 at 1/1 and warn=1 from the edge showing 1/0. warn=0 once EXPIRED. Without the macro, warn stays 0 for all of the above.

Source files
------------

// File: rtl/game_timer.sv
// Two-digit BCD countdown timer with tick prescaler, single-cycle expiry pulse and reload.
// Optional low-time warning output built only when GAME_TIMER_WARN_EN is defined.
module game_timer #(
  parameter int         TICK_DIV     = 50000000,
  parameter logic [3:0] DEFAULT_TENS = 4'd6,
  parameter logic [3:0] DEFAULT_ONES = 4'd0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       reconf,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic       timeout,
  output logic       running,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       warn
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          timeout_q, timeout_d;
  logic          running_q, running_d;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    presc_d   = presc_q;
    timeout_d = 1'b0;
    if (reconf) begin
      tens_d  = clamp_bcd(load_tens);
      ones_d  = clamp_bcd(load_ones);
      presc_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            if (tens_q == 4'd0 && ones_q == 4'd0) begin
              state_d   = EXPIRED;
              timeout_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end
            // 01 -> 00 is the only path to zero, so tens never borrows below 0
            if (tens_q == 4'd0 && ones_q == 4'd1) begin
              state_d   = EXPIRED;
              timeout_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        EXPIRED: ;
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tens_q    <= DEFAULT_TENS;
      ones_q    <= DEFAULT_ONES;
      presc_q   <= '0;
      timeout_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
      running_q <= running_d;
    end
  end

`ifdef GAME_TIMER_WARN_EN
  logic warn_q, warn_d;

  always_comb begin
    warn_d = (state_d != EXPIRED) &&
             ((tens_d == 4'd0) || (tens_d == 4'd1 && ones_d == 4'd0));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) warn_q <= 1'b0;
    else      warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign timeout  = timeout_q;
  assign running  = running_q;
  assign sec_tens = tens_q;
  assign sec_ones = ones_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with TICK_DIV=4; warn expectations follow GAME_TIMER_WARN_EN.
module tb_game_timer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       enable = 1'b0;
  logic       reconf = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic       timeout, running, warn;
  logic [3:0] sec_tens, sec_ones;

  int checks = 0;
  int failures = 0;

`ifdef GAME_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  game_timer #(.TICK_DIV(4), .DEFAULT_TENS(4'd6), .DEFAULT_ONES(4'd0)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .reconf(reconf),
    .load_tens(load_tens), .load_ones(load_ones),
    .timeout(timeout), .running(running),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .warn(warn)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    reconf = 1'b1; load_tens = t; load_ones = o;
    step(1);
    reconf = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({sec_tens, sec_ones, running, timeout, warn} !== {4'd6, 4'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset_assert: got %h/%h run=%b to=%b warn=%b, want 6/0 0 0 0",
               sec_tens, sec_ones, running, timeout, warn);
    end
    #20 RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if ({sec_tens, sec_ones, running, timeout, warn} !== {4'd6, 4'd0, 3'b000}) begin
        failures++;
        $display("FAIL idle_hold cyc%0d: got %h/%h run=%b to=%b warn=%b, want 6/0 0 0 0",
                 i, sec_tens, sec_ones, running, timeout, warn);
      end
    end
  endtask

  task automatic test_countdown();
    logic [3:0] exp_ones;
    do_load(4'd0, 4'd3);
    checks++;
    if ({sec_tens, sec_ones, running, warn} !== {4'd0, 4'd3, 1'b0, WARN_ON}) begin
      failures++;
      $display("FAIL load_03: got %h/%h run=%b warn=%b", sec_tens, sec_ones, running, warn);
    end
    enable = 1'b1;
    step(1);
    checks++;
    if ({sec_tens, sec_ones, running} !== {4'd0, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL enter_run: got %h/%h run=%b, want 0/3 run=1", sec_tens, sec_ones, running);
    end
    for (int k = 1; k <= 12; k++) begin
      step(1);
      exp_ones = 4'(3 - k / 4);
      checks++;
      if ({sec_tens, sec_ones, timeout, running} !== {4'd0, exp_ones, (k == 12), (k < 12)}) begin
        failures++;
        $display("FAIL countdown k=%0d: got %h/%h to=%b run=%b, want 0/%h to=%b run=%b",
                 k, sec_tens, sec_ones, timeout, running, exp_ones, (k == 12), (k < 12));
      end
    end
    checks++;
    if (warn !== 1'b0) begin
      failures++;
      $display("FAIL warn_expired: got %b want 0", warn);
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++;
      if ({sec_tens, sec_ones, timeout, running} !== {4'd0, 4'd0, 2'b00}) begin
        failures++;
        $display("FAIL expired_hold cyc%0d: got %h/%h to=%b run=%b, want 0/0 0 0",
                 i, sec_tens, sec_ones, timeout, running);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_pause();
    do_load(4'd1, 4'd0);
    enable = 1'b1;
    step(3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++;
      if ({sec_tens, sec_ones, running, timeout, warn} !== {4'd1, 4'd0, 2'b00, WARN_ON}) begin
        failures++;
        $display("FAIL pause_hold cyc%0d: got %h/%h run=%b to=%b warn=%b",
                 i, sec_tens, sec_ones, running, timeout, warn);
      end
    end
    enable = 1'b1;
    step(2);
    checks++;
    if ({sec_tens, sec_ones, running} !== {4'd1, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL resume_partial: got %h/%h run=%b, want 1/0 run=1", sec_tens, sec_ones, running);
    end
    step(1);
    checks++;
    if ({sec_tens, sec_ones, running, timeout, warn} !== {4'd0, 4'd9, 2'b10, WARN_ON}) begin
      failures++;
      $display("FAIL resume_borrow: got %h/%h run=%b to=%b warn=%b, want 0/9 1 0 %b",
               sec_tens, sec_ones, running, timeout, warn, WARN_ON);
    end
    enable = 1'b0;
  endtask

  task automatic test_clamp_zero();
    do_load(4'hF, 4'hC);
    checks++;
    if ({sec_tens, sec_ones, warn} !== {4'd9, 4'd9, 1'b0}) begin
      failures++;
      $display("FAIL clamp: got %h/%h warn=%b, want 9/9 0", sec_tens, sec_ones, warn);
    end
    do_load(4'd0, 4'd0);
    checks++;
    if ({sec_tens, sec_ones, timeout, warn} !== {4'd0, 4'd0, 1'b0, WARN_ON}) begin
      failures++;
      $display("FAIL load_00: got %h/%h to=%b warn=%b", sec_tens, sec_ones, timeout, warn);
    end
    enable = 1'b1;
    step(1);
    checks++;
    if ({timeout, running, sec_tens, sec_ones, warn} !== {2'b10, 4'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL zero_expire: got to=%b run=%b %h/%h warn=%b, want to=1 run=0 0/0 0",
               timeout, running, sec_tens, sec_ones, warn);
    end
    step(1);
    checks++;
    if ({timeout, running} !== 2'b00) begin
      failures++;
      $display("FAIL zero_pulse_end: got to=%b run=%b, want 0 0", timeout, running);
    end
    enable = 1'b0;
  endtask

  task automatic test_reconf_terminal();
    do_load(4'd0, 4'd1);
    enable = 1'b1;
    step(4);
    reconf = 1'b1; load_tens = 4'd0; load_ones = 4'd5;
    step(1);
    reconf = 1'b0; enable = 1'b0;
    checks++;
    if ({sec_tens, sec_ones, timeout, running} !== {4'd0, 4'd5, 2'b00}) begin
      failures++;
      $display("FAIL reconf_wins: got %h/%h to=%b run=%b, want 0/5 0 0",
               sec_tens, sec_ones, timeout, running);
    end
    step(1);
    checks++;
    if ({sec_tens, sec_ones, timeout, running} !== {4'd0, 4'd5, 2'b00}) begin
      failures++;
      $display("FAIL reconf_idle: got %h/%h to=%b run=%b, want 0/5 0 0",
               sec_tens, sec_ones, timeout, running);
    end
    do_load(4'd0, 4'd1);
    enable = 1'b1;
    step(4);
    enable = 1'b0;
    step(1);
    checks++;
    if ({sec_tens, sec_ones, timeout, running} !== {4'd0, 4'd1, 2'b00}) begin
      failures++;
      $display("FAIL enable_fall_terminal: got %h/%h to=%b run=%b, want 0/1 0 0",
               sec_tens, sec_ones, timeout, running);
    end
  endtask

  task automatic test_async_reset();
    do_load(4'd5, 4'd5);
    enable = 1'b1;
    step(6);
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({sec_tens, sec_ones, timeout, running, warn} !== {4'd6, 4'd0, 3'b000}) begin
      failures++;
      $display("FAIL async_reset: got %h/%h to=%b run=%b warn=%b, want 6/0 0 0 0",
               sec_tens, sec_ones, timeout, running, warn);
    end
    enable = 1'b0;
    step(1);
    RST = 1'b1;
    step(1);
  endtask

  task automatic test_warn();
    do_load(4'd1, 4'd1);
    enable = 1'b1;
    step(1);
    checks++;
    if ({sec_tens, sec_ones, warn} !== {4'd1, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL warn_11: got %h/%h warn=%b, want 1/1 0", sec_tens, sec_ones, warn);
    end
    step(4);
    checks++;
    if ({sec_tens, sec_ones, warn} !== {4'd1, 4'd0, WARN_ON}) begin
      failures++;
      $display("FAIL warn_10: got %h/%h warn=%b, want 1/0 %b", sec_tens, sec_ones, warn, WARN_ON);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_clamp_zero();
    test_reconf_terminal();
    test_async_reset();
    test_warn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
